// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM state encoding and width default shared by seq_alu.
// The divide ops (1100-1111) are live only in builds with SEQ_ALU_DIV_EN.
package seq_alu_pkg;

    localparam int SEQ_ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_NAND = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_DIV  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;
    localparam logic [3:0] ALU_REM  = 4'b1110;
    localparam logic [3:0] ALU_REMU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_alu_divider.sv
// seq_alu_divider: iterative unsigned restoring divider, one quotient bit per cycle.
// quotient/remainder are valid in the cycle that done is high.
module seq_alu_divider
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = SEQ_ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;

    // Borrow out of the W+1 bit subtraction means the divisor did not fit.
    assign trial    = {rem_q, quo_q[WIDTH-1]};
    assign diff     = trial - {1'b0, dvs_q};
    assign fits     = ~diff[WIDTH];
    assign rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], fits};

    assign quotient  = quo_next;
    assign remainder = rem_next;
    assign done      = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (busy) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            cnt   <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked registered ALU with iterative multiply and optional divide.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise ops 1100-1111 are illegal.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = SEQ_ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             dz,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_chk
        $error("seq_alu: WIDTH must be a power of 2 and at least 4");
    end

    state_t           state;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_sum;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ill;
    logic             is_div;
    logic             accept;

    assign shamt   = b[SHW-1:0];
    assign is_div  = (op[3:2] == 2'b11);
    assign accept  = (state == ST_IDLE) && in_valid;
    assign mul_sum = acc + (mul_b[0] ? mul_a : '0);

    always_comb begin
        alu_r   = '0;
        alu_ill = 1'b0;
        case (op)
            ALU_ADD:  alu_r = a + b;
            ALU_SUB:  alu_r = a - b;
            ALU_MUL:  alu_r = '0;
            ALU_OR:   alu_r = a | b;
            ALU_AND:  alu_r = a & b;
            ALU_XOR:  alu_r = a ^ b;
            ALU_NAND: alu_r = ~(a & b);
            ALU_SLT:  alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_r = {{(WIDTH-1){1'b0}}, a < b};
            ALU_SLL:  alu_r = a << shamt;
            ALU_SRL:  alu_r = a >> shamt;
            ALU_SRA:  alu_r = $unsigned($signed(a) >>> shamt);
            default:  alu_ill = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN
    logic             div_signed;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] div_res;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic             sel_rem;
    logic [WIDTH-1:0] a_keep;

    // DIV and REM have op[0]=0; the divider only ever sees magnitudes.
    assign div_signed = ~op[0];
    assign div_start  = accept && is_div;
    assign dvd_mag    = (div_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign dvs_mag    = (div_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    seq_alu_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            sel_rem  <= 1'b0;
            a_keep   <= '0;
        end else if (div_start) begin
            neg_q    <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= div_signed && a[WIDTH-1];
            div_zero <= (b == '0);
            sel_rem  <= op[1];
            a_keep   <= a;
        end
    end

    // Divide by zero bypasses the sign fix-up: quotient all ones, remainder a.
    always_comb begin
        if (div_zero)
            div_res = sel_rem ? a_keep : '1;
        else if (sel_rem)
            div_res = neg_r ? (~rem + 1'b1) : rem;
        else
            div_res = neg_q ? (~quo + 1'b1) : quo;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            z         <= 1'b0;
            dz        <= 1'b0;
            illegal   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        dz       <= 1'b0;
                        illegal  <= 1'b0;
                        if (op == ALU_MUL) begin
                            mul_a <= a;
                            mul_b <= b;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= ST_MUL;
`ifdef SEQ_ALU_DIV_EN
                        end else if (is_div) begin
                            state <= ST_DIV;
`endif
                        end else begin
                            r         <= alu_r;
                            z         <= (alu_r == '0);
                            illegal   <= alu_ill;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    acc   <= mul_sum;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        r         <= mul_sum;
                        z         <= (mul_sum == '0);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                ST_DIV: begin
                    if (div_done) begin
                        r         <= div_res;
                        z         <= (div_res == '0);
                        dz        <= div_zero;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: random and directed stimulus for seq_alu, scored against a
// behavioural model through an expected-result queue.
module tb_seq_alu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         dz;
        logic         ill;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         z;
    logic         dz;
    logic         illegal;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   bp_mode = 0;
    exp_t q[$];

    seq_alu #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .z         (z),
        .dz        (dz),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint qq;
        longint rr;
        e.r   = '0;
        e.dz  = 1'b0;
        e.ill = 1'b0;
        e.lat = 1;
        e.acc = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd0:  e.r = x + y;
            4'd1:  e.r = x - y;
            4'd2:  begin e.r = x * y; e.lat = W + 1; end
            4'd3:  e.r = x | y;
            4'd4:  e.r = x & y;
            4'd5:  e.r = x ^ y;
            4'd6:  e.r = ~(x & y);
            4'd7:  e.r = (sx < sy) ? 1 : 0;
            4'd8:  e.r = (x < y) ? 1 : 0;
            4'd9:  e.r = x << y[4:0];
            4'd10: e.r = x >> y[4:0];
            4'd11: e.r = $unsigned($signed(x) >>> y[4:0]);
            default: begin
`ifdef SEQ_ALU_DIV_EN
                e.lat = W + 1;
                if (y == 0) begin
                    e.dz = 1'b1;
                    e.r  = (o == 4'd12 || o == 4'd13) ? '1 : x;
                end else if (o == 4'd12 || o == 4'd14) begin
                    qq  = sx / sy;
                    rr  = sx % sy;
                    e.r = (o == 4'd12) ? qq[W-1:0] : rr[W-1:0];
                end else begin
                    e.r = (o == 4'd13) ? x / y : x % y;
                end
`else
                e.ill = 1'b1;
`endif
            end
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    // out_ready policy: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expectation per result and checks it stays put.
    initial begin
        exp_t cur;
        logic holding;
        logic prev_hs;
        holding = 1'b0;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
                    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
                end
                prev_hs = 1'b0;
                if (out_valid) begin
                    if (!holding) begin
                        if (q.size() == 0) begin
                            chk("spurious_result", 64'(out_valid), 64'd0);
                        end else begin
                            cur = q.pop_front();
                            chk("r", 64'(r), 64'(cur.r));
                            chk("z", 64'(z), 64'(cur.z));
                            chk("dz", 64'(dz), 64'(cur.dz));
                            chk("illegal", 64'(illegal), 64'(cur.ill));
                            chk("latency", 64'(cyc - cur.acc + 1),
                                64'(cur.lat));
                            holding = 1'b1;
                        end
                    end else begin
                        chk("hold_r", 64'(r), 64'(cur.r));
                        chk("hold_in_ready", 64'(in_ready), 64'd0);
                    end
                    if (out_ready) begin
                        holding = 1'b0;
                        prev_hs = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        exp_t e;
        int   n;
        n = 0;
        @(posedge clk);
        #2;
        while (!in_ready && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            chk("issue_wait_in_ready", 64'(in_ready), 64'd1);
        end else begin
            e     = model(o, x, y);
            e.acc = cyc + 1;
            op       = o;
            a        = x;
            b        = y;
            in_valid = 1'b1;
            q.push_back(e);
            @(posedge clk);
            #2;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_valid)
            chk("drain_queue", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bad;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        issue(4'd0, 32'hFFFF_FFFF, 32'd1);
        drain();

        issue(4'd2, 32'd7, 32'hFFFF_FFFD);
        bad = 0;
        repeat (W) begin
            @(negedge clk);
            if (in_ready) bad++;
        end
        chk("mul_in_ready_low", 64'(bad), 64'd0);
        drain();

        issue(4'd12, 32'hFFFF_FFF9, 32'd2);
        issue(4'd14, 32'hFFFF_FFF9, 32'd2);
        issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd13, 32'd5, 32'd0);
        issue(4'd15, 32'd5, 32'd0);
        issue(4'd12, 32'hFFFF_FFF9, 32'd0);
        drain();

        bp_mode = 2;
        issue(4'd11, 32'h8000_0000, 32'h24);
        op       = 4'd0;
        a        = 32'd1;
        b        = 32'd1;
        in_valid = 1'b1;
        bad      = 0;
        repeat (5) begin
            @(posedge clk);
            #2;
            if (in_ready || !out_valid || r !== 32'hF800_0000) bad++;
        end
        chk("backpressure_hold", 64'(bad), 64'd0);
        in_valid = 1'b0;
        bp_mode  = 0;
        drain();

        issue(4'd2, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_r", 64'(r), 64'd0);
        @(posedge clk);
        #3;
        q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        issue(4'd0, 32'h1234_5678, 32'h1111_1111);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 80; i++)
            issue(4'($urandom_range(0, 15)), pick(), pick());
        bp_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the team's combinational 32-bit ALU.
- Keeps the 12-op encoding (0000–1011) and its z flag.
- Adds registered results and valid/ready flow control on input and output.
- Adds multi-cycle iterative multiply and new signed/unsigned divide and remainder ops.
- Sits between the datapath's operand registers and the writeback stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from b (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  block accepts a new operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  4  operation code
- out_valid  output  1  result held valid
- out_ready  input  1  consumer takes result
- r  output  WIDTH  result
- z  output  1  r == 0
- dz  output  1  divide or remainder by zero occurred
- illegal  output  1  op unsupported (reserved)

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; r=0, z=0, dz=0, illegal=0; iteration counter and internal registers cleared. Reset mid-operation aborts the operation and discards the result.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready=1. On in_valid, capture a, b, op.
    - op MUL (0010) → MUL.
    - op DIV (1100), DIVU (1101), REM (1110), REMU (1111) → DIV.
    - All other ops: compute in the capture cycle, register the result → DONE.
  - MUL: shift-add, one bit per cycle, WIDTH cycles; low WIDTH bits of the product kept → DONE.
  - DIV: restoring division on magnitudes, one bit per cycle, WIDTH cycles. Signs are fixed up in the final cycle → DONE.
  - DONE: out_valid=1; r, z, dz, illegal held stable. On out_ready → IDLE; out_valid drops next cycle.
- in_ready=0 in MUL, DIV and DONE. Operand inputs are ignored outside IDLE.
- Latency from accept to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
  - DIV/REM: WIDTH+1 cycles.
- Throughput: one operation per (latency + 1) cycles minimum when out_ready is tied high.
- Op semantics (encodings 0000–1011 as in the existing ALU):
  - ADD, SUB, MUL, OR, AND, XOR, NAND.
  - SLT signed and SLTU unsigned: result zero-extended to WIDTH.
  - SLL, SRL, SRA: shift amount is b[SHW-1:0]; upper bits of b are ignored.
- Arithmetic wraps modulo 2^WIDTH.
- Division by zero: quotient = all ones, remainder = a, dz=1. Latency is unchanged; the full WIDTH iterations still run.
- Signed overflow (a = most-negative, b = −1): DIV → most-negative; REM → 0; dz=0.
- Signed remainder takes the sign of the dividend.
- No illegal opcodes exist in the current encoding. If the optional feature below is disabled, 1100–1111 are illegal: r=0, z=1, illegal=1, single-cycle latency.
- z is computed from the final registered r in every case.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- Defined: DIV FSM state and divider datapath present; ops 1100–1111 behave as above.
- Undefined: divider logic removed; ops 1100–1111 flagged illegal; dz is tied to 0.

Decomposition:
- Shared package seq_alu_pkg holds:
  - op encodings as localparams (ALU_ADD … ALU_REMU);
  - FSM state encodings;
  - the WIDTH default constant.
- One natural sub-module, seq_alu_divider: iterative unsigned restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - Sign handling stays in the parent.
- The multiplier stays inline in the parent.

Test Plan:
- WIDTH=32, ADD a=0xFFFFFFFF, b=1, out_ready=1 → out_valid 1 cycle after accept; r=0, z=1; in_ready back high the following cycle.
- MUL a=7, b=−3 (0xFFFFFFFD) → out_valid exactly 33 cycles after accept; r=0xFFFFFFEB; in_ready low throughout.
- DIV signed: a=−7, b=2 → r=−3 (0xFFFFFFFD). Same operands with REM → r=−1.
  - DIV with a=0x80000000, b=0xFFFFFFFF → r=0x80000000, dz=0.
- DIVU a=5, b=0 → r=0xFFFFFFFF, dz=1. REMU a=5, b=0 → r=5, dz=1.
- Backpressure: SRA a=0x80000000, b=0x24 (shift amount 4) with out_ready held low 5 cycles → r=0xF8000000 held stable and out_valid held high; new in_valid ignored until the DONE→IDLE transition.
- Assert rst_n low at MUL iteration 10 → out_valid=0 and r=0 immediately; after release, in_ready=1 and the next ADD returns a correct result.
